// File: rtl/tpm_pkg.sv
// Shared types and helpers for the triple-port memory issue scheduler.
package tpm_pkg;

  localparam int DEFAULT_ADDR_W = 12;
  localparam int DEFAULT_DATA_W = 16;
  localparam int NUM_PORTS      = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0] addr;
    logic [DEFAULT_DATA_W-1:0] data;
    logic                      wen;
  } req_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/tpm_req_fifo.sv
// Per-port request FIFO; wrap-bit pointers, head forced to zero while empty.
module tpm_req_fifo
  import tpm_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type item_t = req_t
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  push,
  input  item_t push_item,
  input  logic  pop,
  output logic  full,
  output logic  empty,
  output item_t head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  item_t          mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head  = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[PTR_W-1:0]] <= push_item;
  end

endmodule

// File: rtl/tpm_port_scheduler.sv
// Issues three client request FIFOs into the triple-ported memory with read credits and an enable/drain FSM.
module tpm_port_scheduler
  import tpm_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_RD     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_wen,
  input  logic              req2_valid,
  output logic              req2_ready,
  input  logic [ADDR_W-1:0] req2_addr,
  input  logic [DATA_W-1:0] req2_data,
  input  logic              req2_wen,
  input  logic              req3_valid,
  output logic              req3_ready,
  input  logic [ADDR_W-1:0] req3_addr,
  input  logic [DATA_W-1:0] req3_data,
  input  logic              req3_wen,

  output logic [ADDR_W-1:0] mem1_addr,
  output logic [DATA_W-1:0] mem1_data_in,
  output logic              mem1_wen,
  output logic              mem1_valid_in,
  output logic [ADDR_W-1:0] mem2_addr,
  output logic [DATA_W-1:0] mem2_data_in,
  output logic              mem2_wen,
  output logic              mem2_valid_in,
  output logic [ADDR_W-1:0] mem3_addr,
  output logic [DATA_W-1:0] mem3_data_in,
  output logic              mem3_wen,
  output logic              mem3_valid_in,

  input  logic              mem_freeze_inputs,
  input  logic              mem1_valid_out,
  input  logic              mem2_valid_out,
  input  logic              mem3_valid_out,

  output logic              idle,
  output logic [15:0]       issue1_count,
  output logic [15:0]       issue2_count,
  output logic [15:0]       issue3_count
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wen;
  } port_req_t;

  localparam int                CRED_W   = $clog2(MAX_RD + 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(MAX_RD);

  state_t                 state;
  port_req_t              in_req     [NUM_PORTS];
  port_req_t              head       [NUM_PORTS];
  logic [NUM_PORTS-1:0]   req_valid;
  logic [NUM_PORTS-1:0]   req_ready;
  logic [NUM_PORTS-1:0]   fifo_full;
  logic [NUM_PORTS-1:0]   fifo_empty;
  logic [NUM_PORTS-1:0]   push;
  logic [NUM_PORTS-1:0]   pop;
  logic [NUM_PORTS-1:0]   valid_in;
  logic [NUM_PORTS-1:0]   valid_out;
  logic [CRED_W-1:0]      rd_out     [NUM_PORTS];
  logic [CRED_W-1:0]      rd_out_nxt [NUM_PORTS];
  logic [15:0]            issue_cnt  [NUM_PORTS];
  logic                   issue_en;
  logic                   credits_clear;
  logic                   credits_clear_nxt;

  assign req_valid = {req3_valid, req2_valid, req1_valid};
  assign valid_out = {mem3_valid_out, mem2_valid_out, mem1_valid_out};
  assign in_req[0] = '{addr: req1_addr, data: req1_data, wen: req1_wen};
  assign in_req[1] = '{addr: req2_addr, data: req2_data, wen: req2_wen};
  assign in_req[2] = '{addr: req3_addr, data: req3_data, wen: req3_wen};

  assign {req3_ready, req2_ready, req1_ready}          = req_ready;
  assign {mem3_valid_in, mem2_valid_in, mem1_valid_in} = valid_in;
  assign mem1_addr    = head[0].addr;
  assign mem1_data_in = head[0].data;
  assign mem1_wen     = head[0].wen;
  assign mem2_addr    = head[1].addr;
  assign mem2_data_in = head[1].data;
  assign mem2_wen     = head[1].wen;
  assign mem3_addr    = head[2].addr;
  assign mem3_data_in = head[2].data;
  assign mem3_wen     = head[2].wen;
  assign issue1_count = issue_cnt[0];
  assign issue2_count = issue_cnt[1];
  assign issue3_count = issue_cnt[2];

  assign issue_en = (state == RUN) || (state == DRAIN);
  assign idle     = (state == IDLE) && (&fifo_empty) && credits_clear;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    tpm_req_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .item_t (port_req_t)
    ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push[p]),
      .push_item (in_req[p]),
      .pop       (pop[p]),
      .full      (fifo_full[p]),
      .empty     (fifo_empty[p]),
      .head      (head[p])
    );
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    credits_clear     = 1'b1;
    credits_clear_nxt = 1'b1;
    for (int p = 0; p < NUM_PORTS; p++) begin
      req_ready[p]  = ~fifo_full[p] & (state != DRAIN);
      push[p]       = req_valid[p] & req_ready[p];
      valid_in[p]   = ~fifo_empty[p] & issue_en & (head[p].wen | (rd_out[p] < CRED_MAX));
      pop[p]        = valid_in[p] & ~mem_freeze_inputs;
      rd_out_nxt[p] = rd_out[p];
      // A return with nothing outstanding is dropped; issue+return in one edge cancels.
      if ((pop[p] && !head[p].wen) && !(valid_out[p] && rd_out[p] != '0)) begin
        rd_out_nxt[p] = rd_out[p] + CRED_W'(1);
      end else if (!(pop[p] && !head[p].wen) && (valid_out[p] && rd_out[p] != '0)) begin
        rd_out_nxt[p] = rd_out[p] - CRED_W'(1);
      end
      if (rd_out[p] != '0)     credits_clear     = 1'b0;
      if (rd_out_nxt[p] != '0) credits_clear_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        rd_out[p]    <= '0;
        issue_cnt[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        rd_out[p] <= rd_out_nxt[p];
        if (pop[p]) issue_cnt[p] <= sat_inc16(issue_cnt[p]);
      end
    end
  end

  // Drain completion looks at post-edge credits so idle follows the last return by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    if (enable) state <= RUN;
        RUN:     if (!enable) state <= DRAIN;
        DRAIN: begin
          if (enable)                                      state <= RUN;
          else if ((&fifo_empty) && credits_clear_nxt)     state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpm_port_scheduler.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
module tb_tpm_port_scheduler;

  localparam int AW    = 12;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int MAXRD = 4;

  typedef enum {M_IDLE, M_RUN, M_DRAIN} mstate_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          freeze;
  logic          valid [3];
  logic [AW-1:0] addr  [3];
  logic [DW-1:0] data  [3];
  logic          wen   [3];
  logic          vout  [3];
  logic          rdy   [3];
  logic [AW-1:0] maddr [3];
  logic [DW-1:0] mdata [3];
  logic          mwen  [3];
  logic          mvin  [3];
  logic [15:0]   cnt   [3];
  logic          idle;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: item = {addr, data, wen}
  logic [AW+DW:0] mq [3][$];
  int             mcred [3];
  int             mcnt  [3];
  mstate_t        mst;

  always #5 clk = ~clk;

  tpm_port_scheduler #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .MAX_RD(MAXRD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .req1_valid(valid[0]), .req1_ready(rdy[0]), .req1_addr(addr[0]), .req1_data(data[0]), .req1_wen(wen[0]),
    .req2_valid(valid[1]), .req2_ready(rdy[1]), .req2_addr(addr[1]), .req2_data(data[1]), .req2_wen(wen[1]),
    .req3_valid(valid[2]), .req3_ready(rdy[2]), .req3_addr(addr[2]), .req3_data(data[2]), .req3_wen(wen[2]),
    .mem1_addr(maddr[0]), .mem1_data_in(mdata[0]), .mem1_wen(mwen[0]), .mem1_valid_in(mvin[0]),
    .mem2_addr(maddr[1]), .mem2_data_in(mdata[1]), .mem2_wen(mwen[1]), .mem2_valid_in(mvin[1]),
    .mem3_addr(maddr[2]), .mem3_data_in(mdata[2]), .mem3_wen(mwen[2]), .mem3_valid_in(mvin[2]),
    .mem_freeze_inputs(freeze),
    .mem1_valid_out(vout[0]), .mem2_valid_out(vout[1]), .mem3_valid_out(vout[2]),
    .idle(idle),
    .issue1_count(cnt[0]), .issue2_count(cnt[1]), .issue3_count(cnt[2])
  );

  task automatic check(input string name, input int p, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s port=%0d got=0x%0h want=0x%0h t=%0t", name, p + 1, act, exp, $time);
    end
  endtask

  function automatic bit m_vin(input int p);
    logic [AW+DW:0] h;
    if (mq[p].size() == 0 || mst == M_IDLE) return 1'b0;
    h = mq[p][0];
    return h[0] || (mcred[p] < MAXRD);
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 3; p++) begin
      mq[p].delete();
      mcred[p] = 0;
      mcnt[p]  = 0;
    end
    mst = M_IDLE;
  endtask

  // Applies one rising edge using the inputs the DUT sampled on it.
  task automatic model_step();
    bit was_empty;
    bit creds_zero;
    bit accept;
    bit rd_issue;
    bit ret;
    logic [AW+DW:0] h;
    was_empty  = 1'b1;
    creds_zero = 1'b1;
    for (int p = 0; p < 3; p++) if (mq[p].size() != 0) was_empty = 1'b0;
    for (int p = 0; p < 3; p++) begin
      accept   = (mq[p].size() < DEPTH) && (mst != M_DRAIN);
      rd_issue = 1'b0;
      if (m_vin(p) && !freeze) begin
        h = mq[p].pop_front();
        if (mcnt[p] < 65535) mcnt[p]++;
        rd_issue = !h[0];
      end
      ret = vout[p] && (mcred[p] > 0);
      mcred[p] = mcred[p] + int'(rd_issue) - int'(ret);
      if (valid[p] && accept) mq[p].push_back({addr[p], data[p], wen[p]});
      if (mcred[p] != 0) creds_zero = 1'b0;
    end
    case (mst)
      M_IDLE:  if (enable) mst = M_RUN;
      M_RUN:   if (!enable) mst = M_DRAIN;
      M_DRAIN: if (enable) mst = M_RUN;
               else if (was_empty && creds_zero) mst = M_IDLE;
      default: mst = M_IDLE;
    endcase
  endtask

  task automatic compare();
    logic [AW+DW:0] h;
    bit all_empty;
    bit creds_zero;
    all_empty  = 1'b1;
    creds_zero = 1'b1;
    for (int p = 0; p < 3; p++) begin
      check("ready", p, 32'(rdy[p]), 32'((mq[p].size() < DEPTH) && (mst != M_DRAIN)));
      check("valid_in", p, 32'(mvin[p]), 32'(m_vin(p)));
      check("issue_count", p, 32'(cnt[p]), 32'(mcnt[p]));
      if (mq[p].size() != 0) begin
        h = mq[p][0];
        all_empty = 1'b0;
        check("mem_addr", p, 32'(maddr[p]), 32'(h[AW+DW:DW+1]));
        check("mem_data", p, 32'(mdata[p]), 32'(h[DW:1]));
        check("mem_wen", p, 32'(mwen[p]), 32'(h[0]));
      end
      if (mcred[p] != 0) creds_zero = 1'b0;
    end
    check("idle", 0, 32'(idle), 32'((mst == M_IDLE) && all_empty && creds_zero));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) model_reset();
      else          model_step();
      compare();
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    enable = 1'b0;
    freeze = 1'b0;
    for (int p = 0; p < 3; p++) begin
      valid[p] = 1'b0; addr[p] = '0; data[p] = '0; wen[p] = 1'b0; vout[p] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
  endtask

  task automatic reset_checks();
    for (int p = 0; p < 3; p++) begin
      check("rst_ready", p, 32'(rdy[p]), 32'd1);
      check("rst_valid_in", p, 32'(mvin[p]), 32'd0);
      check("rst_count", p, 32'(cnt[p]), 32'd0);
      check("rst_addr", p, 32'(maddr[p]), 32'd0);
      check("rst_data", p, 32'(mdata[p]), 32'd0);
      check("rst_wen", p, 32'(mwen[p]), 32'd0);
    end
    check("rst_idle", 0, 32'(idle), 32'd1);
  endtask

  // Holds valid until the port accepts, bounded so a stuck ready cannot hang the run.
  task automatic push(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
    valid[p] = 1'b1; addr[p] = a; data[p] = d; wen[p] = w;
    for (int i = 0; i < 100; i++) begin
      if (rdy[p] === 1'b1) begin
        cyc(1);
        valid[p] = 1'b0;
        return;
      end
      cyc(1);
    end
    n_checks++;
    n_errors++;
    $display("FAIL push_timeout port=%0d got=ready_low want=accept t=%0t", p + 1, $time);
    valid[p] = 1'b0;
  endtask

  task automatic pulse_vout(input int p);
    vout[p] = 1'b1;
    cyc(1);
    vout[p] = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    #1;
    reset_checks();
    cyc(2);
    reset_n = 1'b1;
    cyc(1);

    // Single write on port 1 appears one cycle after the push, then pops.
    enable = 1'b1;
    push(0, 12'h010, 16'hBEEF, 1'b1);
    check("t1_valid_in", 0, 32'(mvin[0]), 32'd1);
    check("t1_addr", 0, 32'(maddr[0]), 32'h010);
    check("t1_data", 0, 32'(mdata[0]), 32'hBEEF);
    check("t1_wen", 0, 32'(mwen[0]), 32'd1);
    cyc(1);
    check("t1_count", 0, 32'(cnt[0]), 32'd1);
    check("t1_valid_after", 0, 32'(mvin[0]), 32'd0);
    check("t1_idle_run", 0, 32'(idle), 32'd0);

    // Read credit limit on port 2.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 6; i++) push(1, AW'(12'h200 + i), 16'h0, 1'b0);
    cyc(5);
    check("t2_count_cap", 1, 32'(cnt[1]), 32'd4);
    check("t2_blocked", 1, 32'(mvin[1]), 32'd0);
    pulse_vout(1);
    cyc(1);
    check("t2_count_one_more", 1, 32'(cnt[1]), 32'd5);
    check("t2_blocked_again", 1, 32'(mvin[1]), 32'd0);
    repeat (6) begin
      pulse_vout(1);
      cyc(1);
    end
    check("t2_count_all", 1, 32'(cnt[1]), 32'd6);

    // Freeze holds heads and counters on all ports.
    do_reset();
    push(0, 12'h0A1, 16'h1111, 1'b1);
    push(1, 12'h0B2, 16'h2222, 1'b0);
    push(2, 12'h0C3, 16'h3333, 1'b1);
    freeze = 1'b1;
    enable = 1'b1;
    cyc(4);
    for (int p = 0; p < 3; p++) begin
      check("t3_frozen_count", p, 32'(cnt[p]), 32'd0);
      check("t3_frozen_valid", p, 32'(mvin[p]), 32'd1);
    end
    check("t3_frozen_addr", 1, 32'(maddr[1]), 32'h0B2);
    freeze = 1'b0;
    cyc(1);
    for (int p = 0; p < 3; p++) check("t3_resume_count", p, 32'(cnt[p]), 32'd1);

    // Full FIFO on port 3 with issue disabled.
    do_reset();
    for (int i = 0; i < 4; i++) push(2, AW'(12'h300 + i), DW'(16'hA000 + i), 1'b1);
    check("t4_full_ready", 2, 32'(rdy[2]), 32'd0);
    enable = 1'b1;
    push(2, 12'h304, 16'hA004, 1'b1);
    cyc(6);
    check("t4_count", 2, 32'(cnt[2]), 32'd5);

    // Drain with two outstanding reads.
    do_reset();
    enable = 1'b1;
    push(0, 12'h100, 16'h0, 1'b0);
    push(0, 12'h101, 16'h0, 1'b0);
    cyc(3);
    enable = 1'b0;
    cyc(1);
    for (int p = 0; p < 3; p++) check("t5_drain_ready", p, 32'(rdy[p]), 32'd0);
    pulse_vout(0);
    check("t5_idle_mid", 0, 32'(idle), 32'd0);
    cyc(1);
    vout[0] = 1'b1;
    check("t5_idle_before_last", 0, 32'(idle), 32'd0);
    cyc(1);
    vout[0] = 1'b0;
    check("t5_idle_after_last", 0, 32'(idle), 32'd1);
    enable = 1'b1;
    cyc(1);
    push(0, 12'h102, 16'h0, 1'b0);
    cyc(2);
    enable = 1'b0;
    cyc(1);
    check("t5_in_drain", 0, 32'(rdy[0]), 32'd0);
    enable = 1'b1;
    cyc(1);
    check("t5_back_to_run", 0, 32'(rdy[0]), 32'd1);
    pulse_vout(0);
    cyc(1);

    // Randomised traffic with an asynchronous reset in the middle.
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 800; c++) begin
      for (int p = 0; p < 3; p++) begin
        valid[p] = 1'($urandom_range(0, 1));
        addr[p]  = AW'($urandom);
        data[p]  = DW'($urandom);
        wen[p]   = 1'($urandom_range(0, 1));
        vout[p]  = ($urandom_range(0, 9) < 4);
      end
      freeze = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      if (c == 400) begin
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        reset_checks();
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        enable  = 1'b1;
      end
      cyc(1);
    end

    clear_inputs();
    cyc(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
